// File: rtl/bucket_hit_counter.sv
// Per-bucket saturating hit counters fed by the one-hot index from the leading-bucket lookup.
// The counters have a registered read port and are wiped by a sequenced clear, one counter per cycle.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | accepting indices; clr_req starts a clear
//  ST_DRAIN | input stalled; the in-flight staged update commits
//  ST_CLEAR | input stalled; zero counter[ptr] each cycle, then return to idle
module bucket_hit_counter #(
  parameter int NUM_BUCKETS = 12,
  parameter int CNT_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUCKETS-1:0] index_in,
  input  logic                   index_vld,
  output logic                   index_rdy,
  input  logic                   rd_req,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic                   rd_ack,
  output logic [CNT_WIDTH-1:0]   rd_data,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic                   err_sticky
);

  localparam int NUM_CNT  = NUM_BUCKETS + 2;
  localparam int NONE_IDX = NUM_BUCKETS;
  localparam int ERR_IDX  = NUM_BUCKETS + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [NUM_BUCKETS-1:0] s_idx;
  logic                   s_vld;
  logic [CNT_WIDTH-1:0]   cnt [NUM_CNT];
  logic [NUM_CNT-1:0]     inc_en;
  logic                   xfer;
  logic                   s_zero;
  logic                   s_multi;
  logic                   last_clr;
  logic [CNT_WIDTH-1:0]   rd_sel;

  assign index_rdy = (state == ST_IDLE);
  assign clr_busy  = (state != ST_IDLE);
  assign xfer      = index_vld & index_rdy;
  assign s_zero    = ~|s_idx;
  // Clearing the lowest set bit leaves something behind only if two or more bits were set.
  assign s_multi   = |(s_idx & (s_idx - NUM_BUCKETS'(1)));
  assign last_clr  = (state == ST_CLEAR) && (ptr == ADDR_WIDTH'(NUM_CNT - 1));

  always_comb begin
    inc_en = '0;
    if (s_vld) begin
      if (s_zero)       inc_en[NONE_IDX]          = 1'b1;
      else if (s_multi) inc_en[ERR_IDX]           = 1'b1;
      else              inc_en[NUM_BUCKETS-1:0]   = s_idx;
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) rd_sel = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            // An index accepted this same cycle still has to drain before clearing starts.
            state <= (s_vld | xfer) ? ST_DRAIN : ST_CLEAR;
            ptr   <= '0;
          end
        end
        ST_DRAIN: begin
          state <= ST_CLEAR;
          ptr   <= '0;
        end
        ST_CLEAR: begin
          if (last_clr) state <= ST_IDLE;
          else          ptr   <= ptr + ADDR_WIDTH'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_vld <= 1'b0;
      s_idx <= '0;
    end else begin
      s_vld <= xfer;
      if (xfer) s_idx <= index_in;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CNT; i++) begin
      if (reset)
        cnt[i] <= '0;
      else if (state == ST_CLEAR && ptr == ADDR_WIDTH'(i))
        cnt[i] <= '0;
      else if (inc_en[i] && cnt[i] != {CNT_WIDTH{1'b1}})
        cnt[i] <= cnt[i] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                err_sticky <= 1'b0;
    else if (last_clr)        err_sticky <= 1'b0;
    else if (inc_en[ERR_IDX]) err_sticky <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) rd_data <= rd_sel;
    end
  end

endmodule
